axi_wr_arbiter: RTL

- Shares one AXI write slave port (AW/W/B channels) between NUM_M upstream masters.
- Round-robin grant; at most one write transaction in flight on the slave side.
- The arbiter routes the granted master's AW, W and B channels, tags AWID with the master index, and checks burst beat count against AWLEN.
- Sits between agent/DUT-side master interfaces and a single axi_interface slave instance.

---
 rtl/axi_arb_pkg.sv | 31 +++
 rtl/axi_wr_arbiter_rr.sv | 33 +++
 rtl/axi_wr_arbiter.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/axi_arb_pkg.sv
// axi_arb_pkg: shared types and helpers for the AXI write-channel arbiter.
// Width macros fall back to defaults when the project define set is absent.
`ifndef ID_W_WIDTH
`define ID_W_WIDTH 4
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef BRESP_WIDTH
`define BRESP_WIDTH 2
`endif

package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        RESP
    } arb_state_e;

    localparam int BID_TAG_W = `ID_W_WIDTH;

    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/axi_wr_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, first requester at or
// after ptr; the pointer itself lives in the parent.
module rr_arbiter #(
    parameter  int NUM_M = 2,
    localparam int IDX_W = $clog2(NUM_M)
) (
    input  logic [NUM_M-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [NUM_M-1:0] gnt_oh,
    output logic [IDX_W-1:0] gnt_idx
);
    import axi_arb_pkg::*;

    always_comb begin
        int  idx;
        logic hit;
        gnt_oh  = '0;
        gnt_idx = '0;
        hit     = 1'b0;
        idx     = int'(ptr);
        if (idx >= NUM_M) idx = 0;
        for (int k = 0; k < NUM_M; k++) begin
            if (en && !hit && req[idx]) begin
                hit         = 1'b1;
                gnt_oh[idx] = 1'b1;
                gnt_idx     = IDX_W'(idx);
            end
            idx = rr_next(idx, NUM_M);
        end
    end

endmodule

// File: rtl/axi_wr_arbiter.sv
// axi_wr_arbiter: shares one AXI write slave port between NUM_M masters,
// one transaction in flight, round-robin grant, beat/BID checking.
module axi_wr_arbiter #(
    parameter  int NUM_M = 2,
    localparam int IDX_W = $clog2(NUM_M)
) (
    input  logic                              aclk,
    input  logic                              aresetn,
    input  logic [NUM_M-1:0]                  s_awvalid,
    output logic [NUM_M-1:0]                  s_awready,
    input  logic [NUM_M*`ID_W_WIDTH-1:0]      s_awid,
    input  logic [NUM_M*`ADDR_WIDTH-1:0]      s_awaddr,
    input  logic [NUM_M*8-1:0]                s_awlen,
    input  logic [NUM_M*3-1:0]                s_awsize,
    input  logic [NUM_M*2-1:0]                s_awburst,
    input  logic [NUM_M-1:0]                  s_awlock,
    input  logic [NUM_M-1:0]                  s_wvalid,
    output logic [NUM_M-1:0]                  s_wready,
    input  logic [NUM_M*`DATA_WIDTH-1:0]      s_wdata,
    input  logic [NUM_M*(`DATA_WIDTH/8)-1:0]  s_wstrb,
    input  logic [NUM_M-1:0]                  s_wlast,
    output logic [NUM_M-1:0]                  s_bvalid,
    input  logic [NUM_M-1:0]                  s_bready,
    output logic [`ID_W_WIDTH-1:0]            s_bid,
    output logic [`BRESP_WIDTH-1:0]           s_bresp,
    output logic                              m_awvalid,
    input  logic                              m_awready,
    output logic [`ID_W_WIDTH+IDX_W-1:0]      m_awid,
    output logic [`ADDR_WIDTH-1:0]            m_awaddr,
    output logic [7:0]                        m_awlen,
    output logic [2:0]                        m_awsize,
    output logic [1:0]                        m_awburst,
    output logic                              m_awlock,
    output logic                              m_wvalid,
    input  logic                              m_wready,
    output logic [`DATA_WIDTH-1:0]            m_wdata,
    output logic [`DATA_WIDTH/8-1:0]          m_wstrb,
    output logic                              m_wlast,
    input  logic                              m_bvalid,
    output logic                              m_bready,
    input  logic [`ID_W_WIDTH+IDX_W-1:0]      m_bid,
    input  logic [`BRESP_WIDTH-1:0]           m_bresp,
    output logic                              busy,
    output logic                              err_beat,
    output logic                              err_bid
);
    import axi_arb_pkg::*;

    localparam int IW = `ID_W_WIDTH;
    localparam int AW = `ADDR_WIDTH;
    localparam int DW = `DATA_WIDTH;
    localparam int SW = `DATA_WIDTH / 8;

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] grant_q, rr_ptr_q;
    logic [7:0]       len_q;
    logic [8:0]       beat_cnt_q;
    logic [NUM_M-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             aw_hs, w_hs, b_hs;
    int               gi;

    rr_arbiter #(.NUM_M(NUM_M)) u_rr (
        .req     (s_awvalid),
        .ptr     (rr_ptr_q),
        .en      (state_q == IDLE),
        .gnt_oh  (pick_oh),
        .gnt_idx (pick_idx)
    );

    assign gi = int'(grant_q);

    // Payloads always follow the granted slice; valids gate meaning.
    assign m_awid    = {grant_q, s_awid[gi*IW +: IW]};
    assign m_awaddr  = s_awaddr[gi*AW +: AW];
    assign m_awlen   = s_awlen[gi*8 +: 8];
    assign m_awsize  = s_awsize[gi*3 +: 3];
    assign m_awburst = s_awburst[gi*2 +: 2];
    assign m_awlock  = s_awlock[grant_q];
    assign m_wdata   = s_wdata[gi*DW +: DW];
    assign m_wstrb   = s_wstrb[gi*SW +: SW];
    assign m_wlast   = s_wlast[grant_q];
    assign s_bid     = m_bid[IW-1:0];
    assign s_bresp   = m_bresp;
    assign busy      = (state_q != IDLE);

    assign aw_hs = (state_q == ADDR) && s_awvalid[grant_q] && m_awready;
    assign w_hs  = (state_q == DATA) && s_wvalid[grant_q] && m_wready;
    assign b_hs  = (state_q == RESP) && m_bvalid && s_bready[grant_q];

    always_comb begin
        state_d   = state_q;
        m_awvalid = 1'b0;
        s_awready = '0;
        m_wvalid  = 1'b0;
        s_wready  = '0;
        m_bready  = 1'b0;
        s_bvalid  = '0;
        err_beat  = 1'b0;
        err_bid   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|pick_oh) state_d = ADDR;
            end
            ADDR: begin
                m_awvalid          = s_awvalid[grant_q];
                s_awready[grant_q] = m_awready;
                if (aw_hs) state_d = DATA;
            end
            DATA: begin
                m_wvalid          = s_wvalid[grant_q];
                s_wready[grant_q] = m_wready;
                if (w_hs) begin
                    if (m_wlast) begin
                        state_d  = RESP;
                        err_beat = (beat_cnt_q != {1'b0, len_q});
                    end else begin
                        err_beat = (beat_cnt_q == {1'b0, len_q});
                    end
                end
            end
            RESP: begin
                s_bvalid[grant_q] = m_bvalid;
                m_bready          = s_bready[grant_q];
                err_bid = m_bvalid && (m_bid[IW +: IDX_W] != grant_q);
                if (b_hs) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            grant_q    <= '0;
            rr_ptr_q   <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            if (state_q == IDLE && |pick_oh) grant_q <= pick_idx;
            if (aw_hs) begin
                len_q      <= m_awlen;
                beat_cnt_q <= '0;
            end
            // Saturate rather than wrap so overlong bursts stay flagged.
            if (w_hs && beat_cnt_q != '1) beat_cnt_q <= beat_cnt_q + 9'd1;
            if (b_hs) rr_ptr_q <= IDX_W'(rr_next(gi, NUM_M));
        end
    end

endmodule
